// File: rtl/perlane_descrambler_pkg.sv
// Shared PCS constants and the per-lane x^58+x^39+1 descramble function.
// Same lane count, width and taps as the TX scrambler.
package perlane_descrambler_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 64;
  localparam int TAP_A  = 39;
  localparam int TAP_B  = 58;
  localparam int HIST_W = 58;
  localparam int BUS_W  = LANES * LANE_W;
  localparam int CNT_W  = 4;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [HIST_W-1:0] hist_t;

  // e = {new word, history}; each output bit
  // folds in the bits 39 and 58 positions older.
  function automatic lane_t descramble(
    input lane_t din,
    input hist_t hist
  );
    logic [LANE_W+HIST_W-1:0] e;
    lane_t d;
    e = {din, hist};
    for (int i = 0; i < LANE_W; i++) begin
      d[i] = e[TAP_B+i]
           ^ e[TAP_B-TAP_A+i]
           ^ e[i];
    end
    return d;
  endfunction

endpackage

// File: rtl/perlane_descrambler_if.sv
// Data/enable bundle of perlane_descrambler.
// master drives in_*, slave (the block) drives out_*.
interface perlane_descrambler_if;
  import perlane_descrambler_pkg::*;

  logic             in_enable;
  logic [BUS_W-1:0] in_rxdata;
  logic             in_rxdata_valid;
  logic [BUS_W-1:0] out_rxdata;
  logic             out_rxdata_valid;
  logic [LANES-1:0] out_locked;

  modport master (
    output in_enable,
    output in_rxdata,
    output in_rxdata_valid,
    input  out_rxdata,
    input  out_rxdata_valid,
    input  out_locked
  );

  modport slave (
    input  in_enable,
    input  in_rxdata,
    input  in_rxdata_valid,
    output out_rxdata,
    output out_rxdata_valid,
    output out_locked
  );

endinterface

// File: rtl/perlane_descrambler_descrambler_64.sv
// One 64-bit lane: history, output register, lock counter.
// in_pop qualifies in_data; out_pop/out_locked are registered.
module descrambler_64
  import perlane_descrambler_pkg::*;
#(
  parameter int LOCK_WORDS = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_enable,
  input  logic  in_pop,
  input  lane_t in_data,
  output lane_t descrambled_result,
  output logic  out_pop,
  output logic  out_locked
);

  localparam logic [CNT_W-1:0] LOCK_CNT =
    CNT_W'(LOCK_WORDS);

  hist_t            hist;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Disable clears the count even on idle cycles.
  always_comb begin
    cnt_nxt = cnt;
    if (!in_enable) begin
      cnt_nxt = '0;
    end else if (in_pop && cnt != LOCK_CNT) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist               <= '0;
      cnt                <= '0;
      descrambled_result <= '0;
      out_pop            <= 1'b0;
      out_locked         <= 1'b0;
    end else begin
      out_pop    <= in_pop;
      cnt        <= cnt_nxt;
      out_locked <= (cnt_nxt == LOCK_CNT);
      if (in_pop) begin
        // History tracks the wire in bypass too.
        hist <= in_data[LANE_W-1:LANE_W-HIST_W];
        descrambled_result <= in_enable
          ? descramble(in_data, hist)
          : in_data;
      end
    end
  end

endmodule

// File: rtl/perlane_descrambler.sv
// Four independent 64b/66b lane descramblers, 1-cycle latency.
// Ports: clk, reset, bus (slave: in_* from lower, out_* to upper).
module perlane_descrambler
  import perlane_descrambler_pkg::*;
#(
  parameter int LOCK_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  perlane_descrambler_if.slave bus
);

  logic [LANES-1:0] pop;
  logic             unused_pops;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    descrambler_64 #(
      .LOCK_WORDS (LOCK_WORDS)
    ) u_lane (
      .clk                (clk),
      .reset              (reset),
      .in_enable          (bus.in_enable),
      .in_pop             (bus.in_rxdata_valid),
      .in_data            (bus.in_rxdata[k*LANE_W +: LANE_W]),
      .descrambled_result (bus.out_rxdata[k*LANE_W +: LANE_W]),
      .out_pop            (pop[k]),
      .out_locked         (bus.out_locked[k])
    );
  end

  // All lanes share one valid; lane 0 speaks for them.
  assign bus.out_rxdata_valid = pop[0];
  assign unused_pops = ^pop[LANES-1:1];

endmodule

// File: tb/tb_perlane_descrambler.sv
// Directed + loopback bench for perlane_descrambler.
// Bit-serial model checked every cycle plus literal checks.
module tb_perlane_descrambler;
  import perlane_descrambler_pkg::*;

  localparam int LW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   run = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  perlane_descrambler_if bus ();

  perlane_descrambler #(
    .LOCK_WORDS (LW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Serial reference: bit n descrambles as s[n]^s[n-39]^s[n-58].
  logic [57:0]  m_hist [4];
  logic [255:0] m_out;
  logic         m_valid;
  int           m_cnt;

  always @(posedge clk) begin : model
    logic [57:0]  h;
    logic [255:0] o;
    logic         b;
    if (reset) begin
      for (int k = 0; k < 4; k++) m_hist[k] <= '0;
      m_out   <= '0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
    end else begin
      o = m_out;
      if (bus.in_rxdata_valid) begin
        for (int k = 0; k < 4; k++) begin
          h = m_hist[k];
          for (int j = 0; j < 64; j++) begin
            b = bus.in_rxdata[64*k+j];
            o[64*k+j] = bus.in_enable ? (b ^ h[38] ^ h[57]) : b;
            h = {h[56:0], b};
          end
          m_hist[k] <= h;
        end
      end
      m_out   <= o;
      m_valid <= bus.in_rxdata_valid;
      if (!bus.in_enable) m_cnt <= 0;
      else if (bus.in_rxdata_valid && m_cnt < LW) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] el;
    if (run) begin
      el = (m_cnt == LW) ? 4'hF : 4'h0;
      total++;
      if (bus.out_rxdata !== m_out ||
          bus.out_rxdata_valid !== m_valid ||
          bus.out_locked !== el) begin
        bad++;
        $display("FAIL model t=%0t got=%h/%b/%h want=%h/%b/%h",
                 $time, bus.out_rxdata, bus.out_rxdata_valid,
                 bus.out_locked, m_out, m_valid, el);
      end
    end
  end

  // TX scrambler: s[n] = p[n]^s[n-39]^s[n-58].
  logic [57:0] tx_hist [4];

  task automatic tx_scramble(input logic [255:0] p,
                             output logic [255:0] s);
    logic sb;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 64; j++) begin
        sb = p[64*k+j] ^ tx_hist[k][38] ^ tx_hist[k][57];
        s[64*k+j] = sb;
        tx_hist[k] = {tx_hist[k][56:0], sb};
      end
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en,
                       input logic [255:0] d);
    bus.in_rxdata_valid = v;
    bus.in_enable = en;
    bus.in_rxdata = d;
    @(negedge clk);
  endtask

  task automatic loop(input int n, input int idle_pct,
                      input bit skip_first);
    logic [255:0] p, s;
    bit first;
    bit v;
    first = skip_first;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(99) >= idle_pct);
      p = rnd256();
      if (v) tx_scramble(p, s);
      else s = rnd256();
      drive(v, 1'b1, s);
      chk("loop_valid", {255'd0, bus.out_rxdata_valid}, {255'd0, v});
      if (v) begin
        if (!first) chk("loop_data", bus.out_rxdata, p);
        first = 1'b0;
      end
    end
  endtask

  localparam logic [63:0] ONE_OUT = 64'h0400_0080_0000_0001;

  initial begin
    logic [255:0] pat;
    for (int k = 0; k < 4; k++) tx_hist[k] = '0;
    bus.in_enable = 1'b1;
    bus.in_rxdata = '0;
    bus.in_rxdata_valid = 1'b0;

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b1, '0);
    run = 1'b1;
    chk("rst_data", bus.out_rxdata, '0);
    chk("rst_vl", {252'd0, bus.out_locked, bus.out_rxdata_valid},
        '0);
    reset = 1'b0;

    // Single bit against zero history
    drive(1'b1, 1'b1, 256'h1);
    chk("one_data", bus.out_rxdata, {192'd0, ONE_OUT});
    chk("one_model", m_out, {192'd0, ONE_OUT});
    chk("one_vl", {252'd0, bus.out_locked, bus.out_rxdata_valid},
        256'h1);
    drive(1'b1, 1'b1, '0);
    chk("zero_data", bus.out_rxdata, '0);
    chk("zero_lock", {252'd0, bus.out_locked}, 256'hF);

    // Bypass, then re-enable
    pat = {8{32'hDEADBEEF}};
    drive(1'b1, 1'b0, pat);
    chk("byp_data", bus.out_rxdata, pat);
    chk("byp_lock", {252'd0, bus.out_locked}, '0);
    drive(1'b1, 1'b1, rnd256());
    chk("reen_lock1", {252'd0, bus.out_locked}, '0);
    drive(1'b0, 1'b1, rnd256());
    chk("idle_lock", {252'd0, bus.out_locked}, '0);
    drive(1'b1, 1'b1, rnd256());
    chk("reen_lock2", {252'd0, bus.out_locked}, 256'hF);
    drive(1'b0, 1'b0, '0);
    chk("idle_dis", {252'd0, bus.out_locked}, '0);

    // Loopback, TX and RX reset together
    reset = 1'b1;
    for (int k = 0; k < 4; k++) tx_hist[k] = '0;
    drive(1'b0, 1'b1, '0);
    reset = 1'b0;
    loop(1000, 0, 1'b0);
    loop(1000, 30, 1'b0);

    // Resync: RX reset only, TX history kept
    reset = 1'b1;
    drive(1'b0, 1'b1, '0);
    reset = 1'b0;
    loop(50, 30, 1'b1);

    // Reset mid-stream while locked
    chk("pre_rst_lock", {252'd0, bus.out_locked}, 256'hF);
    reset = 1'b1;
    drive(1'b1, 1'b1, rnd256());
    chk("mid_rst_data", bus.out_rxdata, '0);
    chk("mid_rst_vl",
        {252'd0, bus.out_locked, bus.out_rxdata_valid}, '0);
    reset = 1'b0;
    drive(1'b1, 1'b1, {4{64'h1}});
    chk("post_rst", bus.out_rxdata, {4{ONE_OUT}});
    drive(1'b0, 1'b1, '0);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
